// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access arbiter: data width,
// FSM state encoding, requester ids and the in-flight transaction record.
package dm_pkg;

    localparam int DM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dm_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    // Address is kept outside the record because its width is a module parameter.
    typedef struct packed {
        logic                 id;
        logic                 we;
        logic [DM_DATA_W-1:0] wdata;
    } dm_txn_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Two-way requester pick: either fixed priority (requester 0 wins a tie) or
// round-robin, where the tie goes to the requester that was not served last.
module dm_rr_pick
    import dm_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic valid,
    output logic winner
);

    // Single-request cases are unconditional; only the tie consults the policy.
    always_comb begin
        valid  = req0 | req1;
        winner = REQ_CPU;
        if (req0 && req1) begin
            winner = (FIXED_PRIO != 0) ? REQ_CPU : ~rr_last;
        end else if (req1) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-requester data-memory controller: picks one requester, runs a single
// three-cycle access (IDLE -> ACCESS -> DONE) and drives the DM pins.
module dm_access_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_W-1:0]    addr0,
    input  logic [ADDR_W-1:0]    addr1,
    input  logic [DM_DATA_W-1:0] wdata0,
    input  logic [DM_DATA_W-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [DM_DATA_W-1:0] rdata0,
    output logic [DM_DATA_W-1:0] rdata1,
    output logic                 busy,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DM_DATA_W-1:0] mem_write_data,
    output logic                 mem_write,
    output logic                 mem_read,
    input  logic [DM_DATA_W-1:0] mem_read_data
);

    dm_state_t                   state_q, state_d;
    dm_txn_t                     txn_q;
    logic [ADDR_W-1:0]           txn_addr_q;
    logic                        rr_last_q;
    logic [1:0][DM_DATA_W-1:0]   rdata_q;
    logic                        pick_vld;
    logic                        pick_id;

    dm_rr_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last_q),
        .valid   (pick_vld),
        .winner  (pick_id)
    );

    // Next state plus all pin outputs; reset forces every strobe and DM pin low
    // so a write caught in ACCESS by reset never reaches the memory.
    always_comb begin
        state_d        = state_q;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        done0          = 1'b0;
        done1          = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ACCESS;
                    gnt0    = !reset && (pick_id == REQ_CPU);
                    gnt1    = !reset && (pick_id == REQ_DBG);
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!reset) begin
                    mem_address    = txn_addr_q;
                    mem_write_data = txn_q.wdata;
                    mem_write      = txn_q.we;
                    mem_read       = ~txn_q.we;
                end
            end
            DONE: begin
                state_d = IDLE;
                done0   = !reset && (txn_q.id == REQ_CPU);
                done1   = !reset && (txn_q.id == REQ_DBG);
            end
            default: state_d = IDLE;
        endcase
    end

    // State, transaction capture at grant, read-data capture at end of ACCESS.
    // rr_last points at requester 1 after reset so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            txn_q      <= '0;
            txn_addr_q <= '0;
            rr_last_q  <= REQ_DBG;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_vld) begin
                txn_q      <= '{id:    pick_id,
                                we:    pick_id ? we1 : we0,
                                wdata: pick_id ? wdata1 : wdata0};
                txn_addr_q <= pick_id ? addr1 : addr0;
            end
            if (state_q == ACCESS) begin
                rr_last_q <= txn_q.id;
                if (!txn_q.we) begin
                    rdata_q[txn_q.id] <= mem_read_data;
                end
            end
        end
    end

    assign rdata0 = rdata_q[REQ_CPU];
    assign rdata1 = rdata_q[REQ_DBG];
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: a round-robin instance wired to a
// behavioural DM, and a fixed-priority instance fed constant read data.
module tb_dm_access_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    always #5 clock = ~clock;

    // round-robin instance
    logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic       gnt0, gnt1, done0, done1, busy, mem_write, mem_read;
    logic [7:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

    // fixed-priority instance
    logic       p_req0 = 0, p_req1 = 0, p_we0 = 0, p_we1 = 0;
    logic [7:0] p_addr0 = 0, p_addr1 = 0, p_wdata0 = 0, p_wdata1 = 0;
    logic       p_gnt0, p_gnt1, p_done0, p_done1, p_busy, p_mem_write, p_mem_read;
    logic [7:0] p_rdata0, p_rdata1, p_mem_address, p_mem_write_data, p_mem_read_data;

    dm_access_arbiter #(.ADDR_W(8), .FIXED_PRIO(0)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
    );

    dm_access_arbiter #(.ADDR_W(8), .FIXED_PRIO(1)) dut_fp (
        .clock(clock), .reset(reset),
        .req0(p_req0), .req1(p_req1), .we0(p_we0), .we1(p_we1),
        .addr0(p_addr0), .addr1(p_addr1), .wdata0(p_wdata0), .wdata1(p_wdata1),
        .gnt0(p_gnt0), .gnt1(p_gnt1), .done0(p_done0), .done1(p_done1),
        .rdata0(p_rdata0), .rdata1(p_rdata1), .busy(p_busy),
        .mem_address(p_mem_address), .mem_write_data(p_mem_write_data),
        .mem_write(p_mem_write), .mem_read(p_mem_read), .mem_read_data(p_mem_read_data)
    );

    // DM model: combinational read, clocked write, reset sets [0]=FF and [1]=00 only
    bit [7:0] mem [256];
    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_write_data;
        if (reset) begin
            mem[0] <= 8'hFF;
            mem[1] <= 8'h00;
        end
    end
    assign mem_read_data   = mem[mem_address];
    assign p_mem_read_data = 8'h5A;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       id;
        logic [7:0] rd;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every done pulse retires the oldest expected access.
    always @(negedge clock) begin
        if (done0 || done1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'({done1, done0}), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_id", 64'({done1, done0}), e.id ? 64'(2) : 64'(1));
                chk("done_rdata", 64'(e.id ? rdata1 : rdata0), 64'(e.rd));
            end
        end
    end

    // One uncontended access; starts just after a rising edge with the DUT idle.
    task automatic access(input logic id, input logic we, input logic [7:0] a,
                          input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        int n;
        if (id) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
        else    begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
        sb.push_back('{id, exp_rd});
        n = 0;
        @(negedge clock);
        while (!(id ? gnt1 : gnt0) && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_gnt_wait"}, 64'(n), 64'(0));
        chk({tag, "_other_gnt"}, 64'(id ? gnt0 : gnt1), 64'(0));
        @(posedge clock); #1;
        req0 = 0; req1 = 0;
        @(negedge clock);
        chk({tag, "_acc_addr"}, 64'(mem_address), 64'(a));
        chk({tag, "_acc_ctl"}, 64'({mem_write, mem_read}), 64'({we, ~we}));
        chk({tag, "_acc_wdata"}, 64'(mem_write_data), 64'(wd));
        chk({tag, "_acc_nodone"}, 64'({done1, done0}), 64'(0));
        @(negedge clock);
        chk({tag, "_done"}, 64'(id ? done1 : done0), 64'(1));
        chk({tag, "_done_mem_idle"},
            64'({mem_write, mem_read, mem_address, mem_write_data}), 64'(0));
        @(posedge clock); #1;
    endtask

    initial begin
        int n, g0, g1;
        int order[$];

        // reset state
        repeat (2) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_outputs", 64'({gnt0, gnt1, done0, done1, busy, mem_write, mem_read,
                                rdata0, rdata1, mem_address, mem_write_data}), 64'(0));
        chk("rst_outputs_fp", 64'({p_gnt0, p_gnt1, p_done0, p_done1, p_busy,
                                   p_mem_write, p_mem_read, p_rdata0, p_rdata1,
                                   p_mem_address, p_mem_write_data}), 64'(0));
        @(posedge clock); #1;

        // T1: read of reset-initialised location
        access(1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, "t1_rd0");

        // T2: requester 1 write then read back; requester 0 data untouched
        access(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, "t2_wr1");
        access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "t2_rd1");
        chk("t2_rdata0_kept", 64'(rdata0), 64'(8'hFF));

        // T6: write/read on requester 0; a later write leaves rdata0 alone
        access(1'b0, 1'b1, 8'h01, 8'h77, 8'hFF, "t6_wr0");
        access(1'b0, 1'b0, 8'h01, 8'h00, 8'h77, "t6_rd0");
        access(1'b0, 1'b1, 8'h01, 8'h11, 8'h77, "t6_wr0b");
        chk("t6_dm01", 64'(mem[1]), 64'(8'h11));

        // T5: reset lands while a write is in ACCESS
        req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h3C;
        @(negedge clock);
        chk("t5_gnt", 64'(gnt0), 64'(1));
        @(posedge clock); #1;
        req0 = 0; reset = 1;
        @(negedge clock);
        chk("t5_rst_pins", 64'({mem_write, mem_read, mem_address, mem_write_data}), 64'(0));
        chk("t5_rst_done", 64'({done1, done0}), 64'(0));
        @(posedge clock); #1;
        reset = 0;
        repeat (3) begin
            @(negedge clock);
            chk("t5_after_rst", 64'({done0, done1, busy, gnt0, gnt1}), 64'(0));
        end
        chk("t5_dm20", 64'(mem[8'h20]), 64'(0));
        chk("t5_rdata_clr", 64'({rdata0, rdata1}), 64'(0));
        @(posedge clock); #1;

        // T3: round-robin with both requests held from reset
        reset = 1;
        req0 = 1; we0 = 0; addr0 = 8'h00;
        req1 = 1; we1 = 0; addr1 = 8'h10;
        @(posedge clock); #1;
        reset = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            chk("t3_one_gnt", 64'(gnt0 & gnt1), 64'(0));
            chk("t3_busy", 64'(busy), 64'(!(gnt0 | gnt1)));
            if (gnt1) begin
                order.push_back(1);
                sb.push_back('{1'b1, 8'hA5});
            end else if (gnt0) begin
                order.push_back(0);
                sb.push_back('{1'b0, 8'hFF});
            end
        end
        chk("t3_ngrants", 64'(order.size()), 64'(4));
        for (int i = 0; i < order.size() && i < 4; i++)
            chk("t3_order", 64'(order[i]), 64'(i % 2));
        @(posedge clock); #1;
        req0 = 0; req1 = 0;

        // T4: fixed priority, both held; requester 1 waits until 0 drops
        p_req0 = 1; p_addr0 = 8'h03;
        p_req1 = 1; p_addr1 = 8'h04;
        g0 = 0; g1 = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            chk("t4_one_gnt", 64'(p_gnt0 & p_gnt1), 64'(0));
            g0 = g0 + int'(p_gnt0);
            g1 = g1 + int'(p_gnt1);
        end
        chk("t4_gnt0_count", 64'(g0), 64'(3));
        chk("t4_gnt1_count", 64'(g1), 64'(0));
        @(posedge clock); #1;
        p_req0 = 0;
        n = 0;
        @(negedge clock);
        while (!p_gnt1 && n < 6) begin
            @(negedge clock);
            n++;
        end
        chk("t4_gnt1_wait", 64'(n), 64'(0));
        chk("t4_rdata0", 64'(p_rdata0), 64'(8'h5A));
        @(posedge clock); #1;
        p_req1 = 0;
        @(negedge clock);
        @(negedge clock);
        chk("t4_done1", 64'(p_done1), 64'(1));
        chk("t4_rdata1", 64'(p_rdata1), 64'(8'h5A));

        @(posedge clock); #1;
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
